// File: rtl/ablk_seq.sv
// Power/reset/enable sequencer for NUM_CH analog blocks: brings one channel up or down at a
// time (PG -> RESETn -> EN and the reverse) with programmable settle delays.
module ablk_seq #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CFG_W  = 4,
  parameter int unsigned T_PG   = 4,
  parameter int unsigned T_RST  = 2,
  parameter int unsigned T_EN   = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_CH-1:0]        CH_REQ,
  input  logic [NUM_CH*CFG_W-1:0]  CFG0_IN,
  input  logic [NUM_CH*CFG_W-1:0]  CFG1_IN,
  input  logic [NUM_CH-1:0]        CFG_LOAD,
  output logic [NUM_CH-1:0]        ABLK_PG,
  output logic [NUM_CH-1:0]        ABLK_RESETn,
  output logic [NUM_CH-1:0]        ABLK_EN,
  output logic [NUM_CH*CFG_W-1:0]  ABLK_CONFIG_0,
  output logic [NUM_CH*CFG_W-1:0]  ABLK_CONFIG_1,
  output logic [NUM_CH-1:0]        CH_ON,
  output logic                     BUSY
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CfgTotW = NUM_CH * CFG_W;

  // Counters load T-1 so the action lands exactly T edges after the previous one.
  localparam logic [CNT_W-1:0] CntPg  = CNT_W'(T_PG - 1);
  localparam logic [CNT_W-1:0] CntRst = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] CntEn  = CNT_W'(T_EN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUpPg,
    StUpRst,
    StDnEn,
    StDnRst
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]      sel_q, sel_d;
  logic [NUM_CH-1:0]    tgt_q, tgt_d;
  logic [NUM_CH-1:0]    pg_q, pg_d;
  logic [NUM_CH-1:0]    rstn_q, rstn_d;
  logic [NUM_CH-1:0]    en_q, en_d;
  logic [NUM_CH-1:0]    on_q, on_d;
  logic [CfgTotW-1:0]   cfg0_q, cfg0_d;
  logic [CfgTotW-1:0]   cfg1_q, cfg1_d;

  logic                 pick_vld;
  logic [IdxW-1:0]      pick_idx;
  logic                 cnt_zero;

  // Lowest-index channel whose request differs from its target state.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (CH_REQ[i] != tgt_q[i]) begin
        pick_vld = 1'b1;
        pick_idx = IdxW'(i);
      end
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    pg_d    = pg_q;
    rstn_d  = rstn_q;
    en_d    = en_q;
    on_d    = on_q;
    cfg0_d  = cfg0_q;
    cfg1_d  = cfg1_q;

    // Explicit reloads only touch fully-on channels, so they never collide with the
    // power-up latch below (that channel is not yet on).
    for (int j = 0; j < int'(NUM_CH); j++) begin
      if (CFG_LOAD[j] && on_q[j]) begin
        cfg0_d[j*CFG_W +: CFG_W] = CFG0_IN[j*CFG_W +: CFG_W];
        cfg1_d[j*CFG_W +: CFG_W] = CFG1_IN[j*CFG_W +: CFG_W];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          sel_d           = pick_idx;
          tgt_d[pick_idx] = CH_REQ[pick_idx];
          if (CH_REQ[pick_idx]) begin
            pg_d[pick_idx] = 1'b0;
            cnt_d          = CntPg;
            state_d        = StUpPg;
          end else begin
            en_d[pick_idx] = 1'b0;
            on_d[pick_idx] = 1'b0;
            cnt_d          = CntEn;
            state_d        = StDnEn;
          end
        end
      end
      StUpPg: begin
        if (cnt_zero) begin
          rstn_d[sel_q]                = 1'b1;
          cfg0_d[sel_q*CFG_W +: CFG_W] = CFG0_IN[sel_q*CFG_W +: CFG_W];
          cfg1_d[sel_q*CFG_W +: CFG_W] = CFG1_IN[sel_q*CFG_W +: CFG_W];
          cnt_d                        = CntRst;
          state_d                      = StUpRst;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StUpRst: begin
        if (cnt_zero) begin
          en_d[sel_q] = 1'b1;
          on_d[sel_q] = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDnEn: begin
        if (cnt_zero) begin
          rstn_d[sel_q] = 1'b0;
          cnt_d         = CntRst;
          state_d       = StDnRst;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDnRst: begin
        if (cnt_zero) begin
          pg_d[sel_q] = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      tgt_q   <= '0;
      pg_q    <= '1;
      rstn_q  <= '0;
      en_q    <= '0;
      on_q    <= '0;
      cfg0_q  <= '0;
      cfg1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      pg_q    <= pg_d;
      rstn_q  <= rstn_d;
      en_q    <= en_d;
      on_q    <= on_d;
      cfg0_q  <= cfg0_d;
      cfg1_q  <= cfg1_d;
    end
  end

  assign ABLK_PG       = pg_q;
  assign ABLK_RESETn   = rstn_q;
  assign ABLK_EN       = en_q;
  assign ABLK_CONFIG_0 = cfg0_q;
  assign ABLK_CONFIG_1 = cfg1_q;
  assign CH_ON         = on_q;
  assign BUSY          = (state_q != StIdle);

endmodule

// File: tb/tb_ablk_seq.sv
// Directed bench for ablk_seq: a per-edge vector table for single-channel up/load/down,
// then hand-written sequences for two-channel ordering, request pulses and mid-sequence reset.
module tb_ablk_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] CH_REQ;
  logic [7:0] CFG0_IN;
  logic [7:0] CFG1_IN;
  logic [1:0] CFG_LOAD;
  logic [1:0] ABLK_PG;
  logic [1:0] ABLK_RESETn;
  logic [1:0] ABLK_EN;
  logic [7:0] ABLK_CONFIG_0;
  logic [7:0] ABLK_CONFIG_1;
  logic [1:0] CH_ON;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ablk_seq #(
    .NUM_CH(2),
    .CFG_W (4),
    .T_PG  (4),
    .T_RST (2),
    .T_EN  (3),
    .CNT_W (8)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CH_REQ       (CH_REQ),
    .CFG0_IN      (CFG0_IN),
    .CFG1_IN      (CFG1_IN),
    .CFG_LOAD     (CFG_LOAD),
    .ABLK_PG      (ABLK_PG),
    .ABLK_RESETn  (ABLK_RESETn),
    .ABLK_EN      (ABLK_EN),
    .ABLK_CONFIG_0(ABLK_CONFIG_0),
    .ABLK_CONFIG_1(ABLK_CONFIG_1),
    .CH_ON        (CH_ON),
    .BUSY         (BUSY)
  );

  // {pg, resetn, en, config0, config1, ch_on, busy}
  logic [24:0] obs;
  assign obs = {ABLK_PG, ABLK_RESETn, ABLK_EN, ABLK_CONFIG_0, ABLK_CONFIG_1, CH_ON, BUSY};

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  load;
    logic [7:0]  c0in;
    logic [7:0]  c1in;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic rst, input logic [1:0] req, input logic [1:0] load,
                     input logic [7:0] c0in, input logic [7:0] c1in, input logic [1:0] pg,
                     input logic [1:0] rstn, input logic [1:0] en, input logic [7:0] c0,
                     input logic [7:0] c1, input logic [1:0] on, input logic busy);
    vec_t v;
    v.rst  = rst;
    v.req  = req;
    v.load = load;
    v.c0in = c0in;
    v.c1in = c1in;
    v.exp  = {pg, rstn, en, c0, c1, on, busy};
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    CH_REQ   = 2'b00;
    CFG_LOAD = 2'b00;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    CH_REQ   = 2'b00;
    CFG_LOAD = 2'b00;
    CFG0_IN  = 8'h00;
    CFG1_IN  = 8'h00;

    // Entries after the reset pair are edges 1..17 of a ch0 up / load / down run.
    //  n  rst req   load   c0in   c1in   pg     rstn   en     c0     c1     on     busy
    add(1, 1, 2'b00, 2'b00, 8'h0A, 8'h05, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    add(1, 0, 2'b00, 2'b00, 8'h0A, 8'h05, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    add(4, 0, 2'b01, 2'b00, 8'h0A, 8'h05, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1);
    add(2, 0, 2'b01, 2'b00, 8'h0A, 8'h05, 2'b10, 2'b01, 2'b00, 8'h0A, 8'h05, 2'b00, 1);
    add(2, 0, 2'b01, 2'b00, 8'h0A, 8'h05, 2'b10, 2'b01, 2'b01, 8'h0A, 8'h05, 2'b01, 0);
    add(1, 0, 2'b01, 2'b01, 8'h03, 8'h0D, 2'b10, 2'b01, 2'b01, 8'h03, 8'h0D, 2'b01, 0);
    add(1, 0, 2'b01, 2'b10, 8'hE7, 8'hC9, 2'b10, 2'b01, 2'b01, 8'h03, 8'h0D, 2'b01, 0);
    add(1, 0, 2'b00, 2'b01, 8'h0B, 8'h06, 2'b10, 2'b01, 2'b00, 8'h0B, 8'h06, 2'b00, 1);
    add(2, 0, 2'b00, 2'b00, 8'h0B, 8'h06, 2'b10, 2'b01, 2'b00, 8'h0B, 8'h06, 2'b00, 1);
    add(2, 0, 2'b00, 2'b00, 8'h0B, 8'h06, 2'b10, 2'b00, 2'b00, 8'h0B, 8'h06, 2'b00, 1);
    add(2, 0, 2'b00, 2'b00, 8'h0B, 8'h06, 2'b11, 2'b00, 2'b00, 8'h0B, 8'h06, 2'b00, 0);

    tick();
    foreach (tbl[k]) begin
      RESET    = tbl[k].rst;
      CH_REQ   = tbl[k].req;
      CFG_LOAD = tbl[k].load;
      CFG0_IN  = tbl[k].c0in;
      CFG1_IN  = tbl[k].c1in;
      tick();
      chk($sformatf("vec%0d", k), 32'(obs), 32'(tbl[k].exp));
    end
    CFG_LOAD = 2'b00;

    // Simultaneous requests: ch0 first, ch1 starts one IDLE edge after ch0 completes.
    do_reset();
    CH_REQ = 2'b11;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 1)  chk("dual_pg_e1", 32'({ABLK_PG, BUSY}), 32'({2'b10, 1'b1}));
      if (e == 7)  chk("dual_en0_e7", 32'({ABLK_EN, CH_ON, BUSY}), 32'({2'b01, 2'b01, 1'b0}));
      if (e == 8)  chk("dual_pg1_e8", 32'({ABLK_PG, BUSY}), 32'({2'b00, 1'b1}));
      if (e == 11) chk("dual_rstn_e11", 32'(ABLK_RESETn), 32'(2'b01));
      if (e == 12) chk("dual_rstn_e12", 32'(ABLK_RESETn), 32'(2'b11));
      if (e == 13) chk("dual_en_e13", 32'(ABLK_EN), 32'(2'b01));
      if (e == 14) chk("dual_en_e14", 32'({ABLK_EN, CH_ON, BUSY}), 32'({2'b11, 2'b11, 1'b0}));
    end

    // Two-cycle request pulse: full up sequence, then full down from IDLE.
    do_reset();
    CH_REQ = 2'b01;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 2)  CH_REQ = 2'b00;
      if (e == 7)  chk("pulse_up_e7", 32'({ABLK_EN, CH_ON, BUSY}), 32'({2'b01, 2'b01, 1'b0}));
      if (e == 8)  chk("pulse_dn_e8", 32'({ABLK_EN, CH_ON, BUSY}), 32'({2'b00, 2'b00, 1'b1}));
      if (e == 10) chk("pulse_rstn_e10", 32'(ABLK_RESETn), 32'(2'b01));
      if (e == 11) chk("pulse_rstn_e11", 32'(ABLK_RESETn), 32'(2'b00));
      if (e == 12) chk("pulse_pg_e12", 32'(ABLK_PG), 32'(2'b10));
      if (e == 13) chk("pulse_pg_e13", 32'({ABLK_PG, BUSY}), 32'({2'b11, 1'b0}));
    end

    // Asynchronous reset while ch0 sits in UP_RST, then re-sequence after release.
    do_reset();
    CFG0_IN = 8'h0A;
    CFG1_IN = 8'h05;
    CH_REQ  = 2'b01;
    for (int e = 1; e <= 5; e++) tick();
    chk("mid_uprst_e5", 32'({ABLK_PG, ABLK_RESETn, ABLK_EN}), 32'({2'b10, 2'b01, 2'b00}));
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_async_rst", 32'(obs), 32'({2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0}));
    tick();
    tick();
    RESET = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) chk("resq_pg_e1", 32'({ABLK_PG, BUSY}), 32'({2'b10, 1'b1}));
      if (e == 6) chk("resq_e6", 32'({ABLK_RESETn, ABLK_EN}), 32'({2'b01, 2'b00}));
      if (e == 7) chk("resq_en_e7", 32'({ABLK_EN, CH_ON, ABLK_CONFIG_0, ABLK_CONFIG_1}),
                      32'({2'b01, 2'b01, 8'h0A, 8'h05}));
      if (e == 8) chk("resq_idle_e8", 32'(BUSY), 32'(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
